// File: rtl/hwmod_mr_pkg.sv
// rtl/hwmod_mr_pkg.sv - shared types, cause indices and range helper for hwmod_mr
// Purpose: FSM state encoding, violation cause bit positions, address range test.
// Ports: none (package).
package hwmod_mr_pkg;

  localparam int CAUSE_W = 6;

  // Cause bit positions inside viol_cause
  localparam int C_ENTRY = 0;
  localparam int C_EXIT  = 1;
  localparam int C_RD    = 2;
  localparam int C_WR    = 3;
  localparam int C_DMA   = 4;
  localparam int C_IRQ   = 5;

  typedef enum logic [1:0] {
    ST_NOTRUN = 2'd0,
    ST_RUN    = 2'd1,
    ST_KILL   = 2'd2
  } state_e;

  // Inclusive range test done in 17 bits so a range ending at 16'hFFFF
  // does not wrap; a zero size never matches.
  function automatic logic addr_in(input logic [15:0] addr,
                                   input logic [15:0] base,
                                   input logic [15:0] size);
    logic [16:0] last;
    last = {1'b0, base} + {1'b0, size} - 17'd1;
    return (size != 16'd0) && ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} <= last);
  endfunction

endpackage

// File: rtl/hwmod_mr_region_chk.sv
// rtl/hwmod_mr_region_chk.sv - per-region access policy check for hwmod_mr
// Purpose: flags CPU reads/writes and DMA accesses that break one region's policy.
// Ports:
//   data_en/data_wr/data_addr : CPU data access
//   dma_en/dma_addr           : DMA access
//   pc_in_tcode               : current pc lies inside trusted code
//   hit                       : CPU or DMA access falls inside this region
//   rd_viol/wr_viol/dma_viol  : policy violation flags for this region
module hwmod_mr_region_chk
  import hwmod_mr_pkg::*;
#(
  parameter logic [15:0] BASE = 16'h0000,
  parameter logic [15:0] SIZE = 16'h0000,
  parameter bit          RP   = 1'b0,
  parameter bit          WP   = 1'b0,
  parameter bit          DP   = 1'b0
) (
  input  logic        data_en,
  input  logic        data_wr,
  input  logic [15:0] data_addr,
  input  logic        dma_en,
  input  logic [15:0] dma_addr,
  input  logic        pc_in_tcode,
  output logic        hit,
  output logic        rd_viol,
  output logic        wr_viol,
  output logic        dma_viol
);

  logic cpu_hit;
  logic dma_hit;

  assign cpu_hit = data_en && addr_in(data_addr, BASE, SIZE);
  assign dma_hit = dma_en && addr_in(dma_addr, BASE, SIZE);

  assign hit      = cpu_hit || dma_hit;
  assign rd_viol  = RP && cpu_hit && !data_wr && !pc_in_tcode;
  assign wr_viol  = WP && cpu_hit &&  data_wr && !pc_in_tcode;
  assign dma_viol = DP && dma_hit;

endmodule

// File: rtl/hwmod_mr.sv
// rtl/hwmod_mr.sv - multi-region security monitor for the openMSP430 core
// Purpose: atomic trusted-code execution plus per-region data/DMA policies;
//   latches violation cause/regions, counts violations, holds a reset request.
// Optional feature: HWMOD_MR_IRQ_GUARD_EN makes irq in trusted code a violation.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   pc                      : current instruction address
//   data_en/data_wr/data_addr : CPU data access
//   dma_en/dma_addr         : DMA access
//   irq                     : interrupt taken
//   viol_reset              : registered core reset request
//   viol_cause              : sticky cause of the last violation event
//   viol_region             : regions involved in the last violation event
//   viol_count              : saturating violation event count
//   in_tcode                : monitor is in RUN
module hwmod_mr
  import hwmod_mr_pkg::*;
#(
  parameter int                 NREG          = 4,
  parameter logic [15:0]        TCODE_BASE    = 16'hA000,
  parameter logic [15:0]        TCODE_SIZE    = 16'h4000,
  parameter logic [16*NREG-1:0] REG_BASE      = {16'h6A00, 16'h0400, 16'hFFC0, 16'h0360},
  parameter logic [16*NREG-1:0] REG_SIZE      = {16'h0040, 16'h0C00, 16'h0020, 16'h0020},
  parameter logic [NREG-1:0]    REG_RP        = 4'b1011,
  parameter logic [NREG-1:0]    REG_WP        = 4'b1111,
  parameter logic [NREG-1:0]    REG_DP        = 4'b1111,
  parameter int                 RST_HOLD      = 8,
  parameter int                 CNT_W         = 8,
  parameter logic [15:0]        RESET_HANDLER = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [15:0]        pc,
  input  logic               data_en,
  input  logic               data_wr,
  input  logic [15:0]        data_addr,
  input  logic               dma_en,
  input  logic [15:0]        dma_addr,
  input  logic               irq,
  output logic               viol_reset,
  output logic [CAUSE_W-1:0] viol_cause,
  output logic [NREG-1:0]    viol_region,
  output logic [CNT_W-1:0]   viol_count,
  output logic               in_tcode
);

  localparam int               HOLD_W     = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);
  localparam logic [15:0]      TCODE_LAST = TCODE_BASE + TCODE_SIZE - 16'd2;

  state_e               state_q;
  logic [HOLD_W-1:0]    hold_q;
  logic [CAUSE_W-1:0]   cause_q;
  logic [NREG-1:0]      region_q;
  logic [CNT_W-1:0]     count_q;
  logic [15:0]          prev_pc_q;
  logic                 viol_reset_q;
  logic                 in_tcode_q;

  logic                 pc_in_tcode;
  logic [NREG-1:0]      hit;
  logic [NREG-1:0]      rd_viol;
  logic [NREG-1:0]      wr_viol;
  logic [NREG-1:0]      dma_viol;
  logic [CAUSE_W-1:0]   cause_d;
  logic [NREG-1:0]      region_d;
  logic                 viol;
  logic [NREG-1:0]      unused_hit;

  assign pc_in_tcode = addr_in(pc, TCODE_BASE, TCODE_SIZE);
  assign unused_hit  = hit;

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    hwmod_mr_region_chk #(
      .BASE (REG_BASE[16*g +: 16]),
      .SIZE (REG_SIZE[16*g +: 16]),
      .RP   (REG_RP[g]),
      .WP   (REG_WP[g]),
      .DP   (REG_DP[g])
    ) u_chk (
      .data_en     (data_en),
      .data_wr     (data_wr),
      .data_addr   (data_addr),
      .dma_en      (dma_en),
      .dma_addr    (dma_addr),
      .pc_in_tcode (pc_in_tcode),
      .hit         (hit[g]),
      .rd_viol     (rd_viol[g]),
      .wr_viol     (wr_viol[g]),
      .dma_viol    (dma_viol[g])
    );
  end

`ifndef HWMOD_MR_IRQ_GUARD_EN
  logic unused_irq;
  assign unused_irq = irq;
`endif

  // All causes active this cycle; everything is masked once in KILL so a
  // held reset is never re-armed or recounted.
  always_comb begin
    cause_d  = '0;
    region_d = rd_viol | wr_viol | dma_viol;
    cause_d[C_ENTRY] = (state_q == ST_NOTRUN) && pc_in_tcode && (pc != TCODE_BASE);
    cause_d[C_EXIT]  = (state_q == ST_RUN) && !pc_in_tcode && (prev_pc_q != TCODE_LAST);
    cause_d[C_RD]    = |rd_viol;
    cause_d[C_WR]    = |wr_viol;
    cause_d[C_DMA]   = |dma_viol;
`ifdef HWMOD_MR_IRQ_GUARD_EN
    // State RUN already covers the legal exit cycle.
    cause_d[C_IRQ]   = irq && (state_q == ST_RUN);
`else
    cause_d[C_IRQ]   = 1'b0;
`endif
    if (state_q == ST_KILL) begin
      cause_d  = '0;
      region_d = '0;
    end
  end

  assign viol = |cause_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_KILL;
      hold_q       <= HOLD_INIT;
      cause_q      <= '0;
      region_q     <= '0;
      count_q      <= '0;
      prev_pc_q    <= 16'h0000;
      viol_reset_q <= 1'b1;
      in_tcode_q   <= 1'b0;
    end else begin
      prev_pc_q <= pc;
      if (viol) begin
        // A violation overrides any legal transition in the same cycle.
        state_q      <= ST_KILL;
        hold_q       <= HOLD_INIT;
        cause_q      <= cause_d;
        region_q     <= region_d;
        viol_reset_q <= 1'b1;
        in_tcode_q   <= 1'b0;
        if (count_q != '1) count_q <= count_q + 1'b1;
      end else begin
        case (state_q)
          ST_NOTRUN: begin
            if (pc == TCODE_BASE) begin
              state_q    <= ST_RUN;
              in_tcode_q <= 1'b1;
            end
          end
          ST_RUN: begin
            // Leaving without a violation implies the exit was legal.
            if (!pc_in_tcode) begin
              state_q    <= ST_NOTRUN;
              in_tcode_q <= 1'b0;
            end
          end
          ST_KILL: begin
            if (hold_q != '0) begin
              hold_q <= hold_q - 1'b1;
            end else if (pc == RESET_HANDLER) begin
              state_q      <= ST_NOTRUN;
              viol_reset_q <= 1'b0;
            end
          end
          default: begin
            state_q      <= ST_KILL;
            hold_q       <= HOLD_INIT;
            viol_reset_q <= 1'b1;
            in_tcode_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign viol_reset  = viol_reset_q;
  assign in_tcode    = in_tcode_q;
  assign viol_cause  = cause_q;
  assign viol_region = region_q;
  assign viol_count  = count_q;

endmodule
